// File: rtl/bcrypt_result_rx.sv
// bcrypt_result_rx: receives the bcrypt core's 1-bit serial result packet and drains it as 32-bit words.
// Optional header timeout is compiled in when BCRYPT_RX_TIMEOUT_EN is defined.
module bcrypt_result_rx #(
  parameter int unsigned N_WORDS        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        core_empty,
  input  logic        core_dout,
  output logic        core_rd_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

  localparam int unsigned       WIDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(N_WORDS - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_HDR = 2'd1;
  localparam logic [1:0] RECV     = 2'd2;
  localparam logic [1:0] DRAIN    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;
  logic [WIDX_W-1:0] next_idx;
  logic              core_rd_en_d, out_valid_d, out_last_d, err_d;
  logic [31:0]       out_data_d;
  logic [31:0]       word_buf_q [N_WORDS];
  logic [31:0]       recv_word;
  logic              handshake;
  logic              tmo_hit;

  assign handshake = out_valid & out_ready;
  assign next_idx  = word_idx_q + 1'b1;
  assign busy      = (state_q != IDLE);

  // Current word with the incoming bit merged in at position bit_cnt.
  always_comb begin
    recv_word            = word_buf_q[word_idx_q];
    recv_word[bit_cnt_q] = core_dout;
  end

  always_ff @(posedge CLK) begin
    if (state_q == RECV) begin
      word_buf_q[word_idx_q] <= recv_word;
    end
  end

`ifdef BCRYPT_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == WAIT_HDR && !core_dout && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_idx_d   = word_idx_q;
    core_rd_en_d = 1'b0;
    out_valid_d  = out_valid;
    out_last_d   = out_last;
    out_data_d   = out_data;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!core_empty) begin
          core_rd_en_d = 1'b1;
          state_d      = WAIT_HDR;
        end
      end
      WAIT_HDR: begin
        if (core_dout) begin
          state_d    = RECV;
          bit_cnt_d  = '0;
          word_idx_d = '0;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RECV: begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          if (word_idx_q == LAST_IDX) begin
            state_d     = DRAIN;
            word_idx_d  = '0;
            out_valid_d = 1'b1;
            // A single-word packet finishes its only word on this very edge.
            out_data_d  = (N_WORDS == 1) ? recv_word : word_buf_q[0];
            out_last_d  = (N_WORDS == 1);
          end else begin
            word_idx_d = next_idx;
          end
        end
      end
      DRAIN: begin
        if (handshake) begin
          if (out_last) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            word_idx_d  = '0;
            state_d     = IDLE;
          end else begin
            word_idx_d = next_idx;
            out_data_d = word_buf_q[next_idx];
            out_last_d = (next_idx == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      core_rd_en <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_idx_q <= word_idx_d;
      core_rd_en <= core_rd_en_d;
      out_valid  <= out_valid_d;
      out_last   <= out_last_d;
      out_data   <= out_data_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_bcrypt_result_rx.sv
// Directed self-checking bench for bcrypt_result_rx with a behavioural serial core model.
// Timeout scenario is compiled in when BCRYPT_RX_TIMEOUT_EN is defined.
module tb_bcrypt_result_rx;

  logic        CLK = 1'b0;
  logic        rst;
  logic        core_empty;
  logic        core_dout;
  logic        core_rd_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pq [$];
  logic [31:0] got_q [$];
  logic        last_q [$];
  int          rd_cnt    = 0;
  int          rd_pulses = 0;
  int          rd_viol   = 0;
  int          err_cnt   = 0;
  bit          pkt_open  = 1'b0;
  bit          core_mute = 1'b0;
  bit          core_active = 1'b0;

  always #5 CLK = ~CLK;

  bcrypt_result_rx #(
    .N_WORDS       (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .core_empty(core_empty),
    .core_dout (core_dout),
    .core_rd_en(core_rd_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  // Core model: header two cycles after the request, then 8 words LSB-first.
  initial begin : core_model
    logic [31:0] w [8];
    core_dout = 1'b0;
    forever begin
      @(negedge CLK);
      if (core_rd_en) begin
        rd_cnt++;
        if (!core_mute) begin
          for (int i = 0; i < 8; i++) w[i] = (pq.size() > 0) ? pq.pop_front() : 32'h0;
          core_active = 1'b1;
          repeat (2) @(negedge CLK);
          core_dout = 1'b1;
          for (int b = 0; b < 256; b++) begin
            @(negedge CLK);
            core_dout = w[b / 32][b % 32];
          end
          @(negedge CLK);
          core_dout   = 1'b0;
          core_active = 1'b0;
        end
      end
    end
  end

  // Records handshakes and flags any request issued while a packet is still outstanding.
  always @(negedge CLK) begin
    if (rst) begin
      pkt_open = 1'b0;
    end else begin
      if (core_rd_en) begin
        if (pkt_open) rd_viol++;
        pkt_open = 1'b1;
        rd_pulses++;
      end
      if (err) begin
        err_cnt++;
        pkt_open = 1'b0;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        if (out_last) pkt_open = 1'b0;
      end
    end
  end

  task automatic wait_rd(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (rd_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic wait_words(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic wait_quiet(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!core_active && !busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    core_empty = 1'b1;
    out_ready  = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({core_rd_en, out_valid, out_last, busy, err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000", {core_rd_en, out_valid, out_last, busy, err});
    end
    checks++;
    if (out_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=00000000", out_data);
    end
    @(negedge CLK);
    rst = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic;
    bit ok;
    int rd0, pulses0;
    got_q.delete();
    last_q.delete();
    for (int i = 0; i < 8; i++) pq.push_back(32'(i + 1));
    rd0        = rd_cnt;
    pulses0    = rd_pulses;
    core_empty = 1'b0;
    wait_rd(rd0 + 1, ok);
    core_empty = 1'b1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_rd_en got=none want=request");
    end
    wait_words(8, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_count got=%0d want=8", got_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({got_q[i], last_q[i]} !== {32'(i + 1), (i == 7)}) begin
        failures++;
        $display("FAIL basic_word%0d got=%h/%b want=%h/%b", i, got_q[i], last_q[i], i + 1, i == 7);
      end
    end
    wait_quiet(ok);
    checks++;
    if ((rd_pulses - pulses0) !== 1 || !ok) begin
      failures++;
      $display("FAIL basic_one_pulse got=%0d want=1", rd_pulses - pulses0);
    end
  endtask

  task automatic test_stall;
    bit ok;
    int rd0;
    logic [31:0] exp [8];
    exp = '{32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADBEEF,
            32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    got_q.delete();
    last_q.delete();
    for (int i = 0; i < 8; i++) pq.push_back(exp[i]);
    rd0        = rd_cnt;
    core_empty = 1'b0;
    wait_rd(rd0 + 1, ok);
    core_empty = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge CLK);
      #1;
      if (out_valid && out_data == 32'hDEADBEEF) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_reach got=absent want=DEADBEEF");
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      #1;
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
        failures++;
        $display("FAIL stall_hold%0d got=%b/%b/%h want=1/0/deadbeef", c, out_valid, out_last,
                 out_data);
      end
    end
    out_ready = 1'b1;
    wait_words(8, ok);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({got_q[i], last_q[i]} !== {exp[i], (i == 7)}) begin
        failures++;
        $display("FAIL stall_word%0d got=%h/%b want=%h/%b", i, got_q[i], last_q[i], exp[i], i == 7);
      end
    end
    wait_quiet(ok);
  endtask

  task automatic run_two(input logic [31:0] base_a, input logic [31:0] step_a,
                         input logic [31:0] base_b, input logic [31:0] step_b, input string tag);
    bit ok;
    int rd0, pulses0, viol0;
    logic [31:0] e;
    got_q.delete();
    last_q.delete();
    for (int i = 0; i < 8; i++) pq.push_back(base_a + step_a * 32'(i));
    for (int i = 0; i < 8; i++) pq.push_back(base_b + step_b * 32'(i));
    rd0        = rd_cnt;
    pulses0    = rd_pulses;
    viol0      = rd_viol;
    core_empty = 1'b0;
    wait_rd(rd0 + 2, ok);
    core_empty = 1'b1;
    wait_words(16, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_count got=%0d want=16", tag, got_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      e = (i < 8) ? base_a + step_a * 32'(i) : base_b + step_b * 32'(i - 8);
      checks++;
      if ({got_q[i], last_q[i]} !== {e, (i == 7 || i == 15)}) begin
        failures++;
        $display("FAIL %s_word%0d got=%h/%b want=%h/%b", tag, i, got_q[i], last_q[i], e,
                 i == 7 || i == 15);
      end
    end
    wait_quiet(ok);
    checks++;
    if ((rd_pulses - pulses0) !== 2 || (rd_viol - viol0) !== 0) begin
      failures++;
      $display("FAIL %s_requests got=%0d/%0d want=2/0", tag, rd_pulses - pulses0, rd_viol - viol0);
    end
  endtask

  task automatic test_back_to_back;
    run_two(32'hA0000000, 32'h1, 32'hB0000000, 32'h1, "b2b");
  endtask

  task automatic test_extremes;
    run_two(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, "extreme");
  endtask

  task automatic test_reset_mid;
    bit ok;
    int rd0;
    got_q.delete();
    last_q.delete();
    for (int i = 0; i < 8; i++) pq.push_back(32'h12345678 + 32'(i));
    rd0        = rd_cnt;
    core_empty = 1'b0;
    wait_rd(rd0 + 1, ok);
    core_empty = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK);
      if (core_dout) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rstmid_header got=none want=header");
    end
    // Bits 0..99 land on the next 100 edges; reset coincides with bit 100.
    repeat (100) @(posedge CLK);
    #1;
    rst = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if ({busy, out_valid, core_rd_en} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_idle got=%b want=000", {busy, out_valid, core_rd_en});
    end
    rst = 1'b0;
    wait_quiet(ok);
    repeat (10) @(negedge CLK);
    checks++;
    if (got_q.size() !== 0 || !ok) begin
      failures++;
      $display("FAIL rstmid_dropped got=%0d want=0", got_q.size());
    end
    for (int i = 0; i < 8; i++) pq.push_back(32'h01020304 * 32'(i + 1));
    rd0        = rd_cnt;
    core_empty = 1'b0;
    wait_rd(rd0 + 1, ok);
    core_empty = 1'b1;
    wait_words(8, ok);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({got_q[i], last_q[i]} !== {32'h01020304 * 32'(i + 1), (i == 7)}) begin
        failures++;
        $display("FAIL rstmid_next%0d got=%h/%b want=%h/%b", i, got_q[i], last_q[i],
                 32'h01020304 * 32'(i + 1), i == 7);
      end
    end
    wait_quiet(ok);
  endtask

`ifdef BCRYPT_RX_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    int cyc;
    core_mute  = 1'b1;
    core_empty = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      if (core_rd_en) begin
        ok = 1'b1;
        break;
      end
    end
    core_empty = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK);
      #1;
      if (err) begin
        cyc = k;
        break;
      end
    end
    checks++;
    if (cyc !== 16 || !ok) begin
      failures++;
      $display("FAIL timeout_cycle got=%0d want=16", cyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle got=%b want=0", busy);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse got=%b want=0", err);
    end
    core_mute = 1'b0;
    repeat (4) @(negedge CLK);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_extremes();
`ifdef BCRYPT_RX_TIMEOUT_EN
    test_timeout();
`else
    checks++;
    if (err_cnt !== 0) begin
      failures++;
      $display("FAIL err_tied got=%0d want=0", err_cnt);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
